// File: rtl/pkt_flit_pkg.sv
// Package shared by the packet-aware flit buffer.
// Contents:
//   FT_*                 2-bit flit type codes (upper two bits of a flit).
//   is_head() / is_tail() decode a flit type.
//   wr_state_t           write-side packet-tracking state machine encoding.
package pkt_flit_pkg;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    // A single-flit packet (11) is both a head and a tail, so a
    // per-bit decode covers all four codes.
    function automatic logic is_head(input logic [1:0] ft);
        return ft[0];
    endfunction

    function automatic logic is_tail(input logic [1:0] ft);
        return ft[1];
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } wr_state_t;

endpackage

// File: rtl/pkt_len_fifo.sv
// Synchronous FIFO of packet lengths, one entry per complete packet in the
// flit buffer.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_len    enqueue a length (written when not full or when popping)
//   pop               dequeue the front entry (ignored when empty)
//   front             length at the head of the queue (undefined when empty)
//   count             number of stored entries
//   empty             count == 0
module pkt_len_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CNT_W-1:0] push_len,
    input  logic             pop,
    output logic [CNT_W-1:0] front,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign front   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_len;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_flit_buffer.sv
// Packet-aware flit FIFO for a router input port. Valid/ready on both sides,
// one clock. Packet boundaries are tracked by a write-side state machine and
// a side FIFO of packet lengths so the route/arbiter logic can see the head
// packet's dist and length before draining it.
// Flit = {type[1:0], dist[WIDTH-3:0]}; type 00 body, 01 head, 10 tail, 11 single.
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   in_flit/in_valid/in_ready write side (in_ready depends on occupancy only)
//   out_flit/out_valid/out_ready read side (out_flit is 0 when !out_valid)
//   free_slots                DEPTH - stored flits
//   pkt_count                 complete packets held
//   head_pkt_vld/head_dist/head_pkt_len  status of the complete packet at head
//   err_proto                 one-cycle pulse after a malformed flit is dropped
// Config macro: PKT_FLIT_BUF_CUT_THROUGH_EN
//   defined   -> out_valid whenever any flit is stored (cut-through)
//   undefined -> out_valid only once a complete packet is stored
module pkt_flit_buffer
    import pkt_flit_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_flit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_flit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] free_slots,
    output logic [CNT_W-1:0] pkt_count,
    output logic             head_pkt_vld,
    output logic [WIDTH-3:0] head_dist,
    output logic [CNT_W-1:0] head_pkt_len,
    output logic             err_proto
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cur_len, cur_len_nxt, cur_len_inc, push_len;
    logic [CNT_W-1:0] len_front, len_count;
    wr_state_t        state, state_nxt;
    logic             accept, store, drop, len_push, pop, pop_tail, len_empty;
    logic             err_q, non_empty;
    logic [1:0]       in_type, head_type;
    logic [WIDTH-1:0] head_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready   = (count != CNT_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign in_type    = in_flit[WIDTH-1 -: 2];
    assign free_slots = CNT_W'(DEPTH) - count;
    assign non_empty  = (count != '0);

    // Saturates so an oversized packet cannot wrap the length field.
    assign cur_len_inc = (cur_len == CNT_W'(DEPTH)) ? cur_len : cur_len + CNT_W'(1);

    // Write FSM: decides whether an accepted flit is stored or dropped, and
    // when a finished packet's length goes into the side FIFO.
    always_comb begin
        state_nxt   = state;
        cur_len_nxt = cur_len;
        store       = 1'b0;
        drop        = 1'b0;
        len_push    = 1'b0;
        push_len    = cur_len_inc;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (in_type == FT_SINGLE) begin
                        store    = 1'b1;
                        len_push = 1'b1;
                        push_len = CNT_W'(1);
                    end else if (in_type == FT_HEAD) begin
                        store       = 1'b1;
                        cur_len_nxt = CNT_W'(1);
                        state_nxt   = ST_IN_PKT;
                    end else begin
                        drop = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    // A stray head/single is dropped; the open packet carries on.
                    if (is_head(in_type)) begin
                        drop = 1'b1;
                    end else begin
                        store       = 1'b1;
                        cur_len_nxt = cur_len_inc;
                        if (is_tail(in_type)) begin
                            len_push  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Read side
    assign head_word = mem[rd_ptr];
    assign head_type = head_word[WIDTH-1 -: 2];

`ifdef PKT_FLIT_BUF_CUT_THROUGH_EN
    assign out_valid = non_empty;
`else
    // The oldest packet is complete whenever any tail is stored, so all of
    // its flits are present once pkt_count is non-zero.
    assign out_valid = non_empty && !len_empty;
`endif

    assign pop      = out_valid && out_ready;
    assign pop_tail = pop && is_tail(head_type);
    assign out_flit = out_valid ? head_word : '0;

    // Status is only meaningful while the head packet is complete and its
    // head flit has not yet been consumed.
    assign head_pkt_vld = non_empty && !len_empty && is_head(head_type);
    assign head_dist    = head_pkt_vld ? head_word[WIDTH-3:0] : '1;
    assign head_pkt_len = head_pkt_vld ? len_front : '0;
    assign pkt_count    = len_count;
    assign err_proto    = err_q;

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= ST_IDLE;
            cur_len <= '0;
            err_q   <= 1'b0;
        end else begin
            if (store) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            state   <= state_nxt;
            cur_len <= cur_len_nxt;
            err_q   <= drop;
        end
    end

    pkt_len_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_len_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (len_push),
        .push_len (push_len),
        .pop      (pop_tail),
        .front    (len_front),
        .count    (len_count),
        .empty    (len_empty)
    );

endmodule

// File: tb/tb_pkt_flit_buffer.sv
module tb_pkt_flit_buffer;

    localparam int WIDTH = 10;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_flit;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_flit;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] pkt_count;
    logic             head_pkt_vld;
    logic [WIDTH-3:0] head_dist;
    logic [CNT_W-1:0] head_pkt_len;
    logic             err_proto;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_flit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_flit      (in_flit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .free_slots   (free_slots),
        .pkt_count    (pkt_count),
        .head_pkt_vld (head_pkt_vld),
        .head_dist    (head_dist),
        .head_pkt_len (head_pkt_len),
        .err_proto    (err_proto)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge and
    // inputs changed afterwards take effect at the following edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] f;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_flit = '0;

        // 1: reset
        cyc(); cyc();
        check("rst_free",   32'(free_slots),   32'd8);
        check("rst_pkts",   32'(pkt_count),    32'd0);
        check("rst_ovld",   32'(out_valid),    32'd0);
        check("rst_hdist",  32'(head_dist),    32'hFF);
        check("rst_inrdy",  32'(in_ready),     32'd1);
        check("rst_hvld",   32'(head_pkt_vld), 32'd0);
        check("rst_hlen",   32'(head_pkt_len), 32'd0);
        check("rst_err",    32'(err_proto),    32'd0);
        rst_n = 1'b1;
        cyc();

        // 2: three-flit packet, store-and-forward visibility
        in_valid = 1'b1; in_flit = 10'h105; cyc();
        check("p3_ovld_h",  32'(out_valid),    32'd0);
        check("p3_free_h",  32'(free_slots),   32'd7);
        in_flit = 10'h000; cyc();
        check("p3_ovld_b",  32'(out_valid),    32'd0);
        in_flit = 10'h200; cyc();
        in_valid = 1'b0;
        check("p3_ovld_t",  32'(out_valid),    32'd1);
        check("p3_pkts",    32'(pkt_count),    32'd1);
        check("p3_hvld",    32'(head_pkt_vld), 32'd1);
        check("p3_hlen",    32'(head_pkt_len), 32'd3);
        check("p3_hdist",   32'(head_dist),    32'h05);
        check("p3_oflit0",  32'(out_flit),     32'h105);
        check("p3_free",    32'(free_slots),   32'd5);
        out_ready = 1'b1; cyc();
        check("p3_oflit1",  32'(out_flit),     32'h000);
        check("p3_hvld_mid",32'(head_pkt_vld), 32'd0);
        cyc();
        check("p3_oflit2",  32'(out_flit),     32'h200);
        cyc();
        out_ready = 1'b0;
        check("p3_empty",   32'(out_valid),    32'd0);
        check("p3_pkts0",   32'(pkt_count),    32'd0);
        check("p3_free8",   32'(free_slots),   32'd8);

        // 3: fill with one 8-flit packet, then write attempt while full + pop
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_flit = (i == 0) ? 10'h101 : (i == 7) ? 10'h200 : 10'h000;
            cyc();
        end
        check("full_free",  32'(free_slots),   32'd0);
        check("full_inrdy", 32'(in_ready),     32'd0);
        check("full_pkts",  32'(pkt_count),    32'd1);
        check("full_hlen",  32'(head_pkt_len), 32'd8);
        check("full_hdist", 32'(head_dist),    32'h01);
        in_flit = 10'h301; out_ready = 1'b1; cyc();
        in_valid = 1'b0;
        check("full_nowr",  32'(free_slots),   32'd1);
        check("full_noerr", 32'(err_proto),    32'd0);
        check("full_next",  32'(out_flit),     32'h000);
        for (int i = 0; i < 7; i++) cyc();
        out_ready = 1'b0;
        check("full_drain", 32'(out_valid),    32'd0);
        check("full_free8", 32'(free_slots),   32'd8);
        check("full_pkts0", 32'(pkt_count),    32'd0);

        // 4: malformed body in IDLE, then a single-flit packet
        in_valid = 1'b1; in_flit = 10'h000; cyc();
        in_valid = 1'b0;
        check("mal_err",    32'(err_proto),    32'd1);
        check("mal_free",   32'(free_slots),   32'd8);
        cyc();
        check("mal_errclr", 32'(err_proto),    32'd0);
        in_valid = 1'b1; in_flit = 10'h30A; cyc();
        in_valid = 1'b0;
        check("sgl_pkts",   32'(pkt_count),    32'd1);
        check("sgl_hlen",   32'(head_pkt_len), 32'd1);
        check("sgl_hdist",  32'(head_dist),    32'h0A);
        check("sgl_oflit",  32'(out_flit),     32'h30A);
        out_ready = 1'b1; cyc();
        out_ready = 1'b0;
        check("sgl_pkts0",  32'(pkt_count),    32'd0);

        // 4b: stray single inside an open packet is dropped, packet continues
        in_valid = 1'b1; in_flit = 10'h102; cyc();
        in_flit = 10'h304; cyc();
        check("mid_err",    32'(err_proto),    32'd1);
        check("mid_free",   32'(free_slots),   32'd7);
        in_flit = 10'h200; cyc();
        in_valid = 1'b0;
        check("mid_errclr", 32'(err_proto),    32'd0);
        check("mid_hlen",   32'(head_pkt_len), 32'd2);
        check("mid_hdist",  32'(head_dist),    32'h02);
        check("mid_pkts",   32'(pkt_count),    32'd1);
        out_ready = 1'b1; cyc();
        check("mid_oflit1", 32'(out_flit),     32'h200);
        cyc();
        out_ready = 1'b0;
        check("mid_free8",  32'(free_slots),   32'd8);

        // 5: stream 20 single-flit packets with continuous out_ready
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            f = {2'b11, 8'(i + 8'h10)};
            in_flit = f;
            cyc();
            check($sformatf("strm_flit%0d", i), 32'(out_flit),   32'(f));
            check($sformatf("strm_free%0d", i), 32'(free_slots), 32'd7);
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        check("strm_empty", 32'(out_valid),    32'd0);
        check("strm_free8", 32'(free_slots),   32'd8);

        // 6: lone head flit
        in_valid = 1'b1; in_flit = 10'h103; cyc();
        in_valid = 1'b0;
`ifdef PKT_FLIT_BUF_CUT_THROUGH_EN
        check("ct_ovld",    32'(out_valid),    32'd1);
        check("ct_oflit",   32'(out_flit),     32'h103);
`else
        check("sf_ovld",    32'(out_valid),    32'd0);
        check("sf_oflit",   32'(out_flit),     32'h000);
`endif
        check("lone_hvld",  32'(head_pkt_vld), 32'd0);
        check("lone_hdist", 32'(head_dist),    32'hFF);
        check("lone_free",  32'(free_slots),   32'd7);

        // Mid-packet reset discards the open packet and returns FSM to IDLE
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        check("mrst_free",  32'(free_slots),   32'd8);
        check("mrst_ovld",  32'(out_valid),    32'd0);
        in_valid = 1'b1; in_flit = 10'h3FF; cyc();
        in_valid = 1'b0;
        check("mrst_pkts",  32'(pkt_count),    32'd1);
        check("mrst_err",   32'(err_proto),    32'd0);
        check("mrst_oflit", 32'(out_flit),     32'h3FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
